// File: rtl/dmac_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : dmac_fifo_fwft
// Brief    : First-word-fall-through FIFO between the DMAC read and write
//            engines, with occupancy count, almost flags and flush.
//            Optional sticky overflow/underflow flags: DMAC_FIFO_ERR_FLAG_EN
// Revision : 1.0 - initial release
// ============================================================================
module dmac_fifo_fwft #(
    parameter int DEPTH_LG2     = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  wren_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  full_o,
    output logic                  afull_o,
    input  logic                  rden_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  empty_o,
    output logic                  aempty_o,
    output logic [DEPTH_LG2:0]    count_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

    localparam int c_depth = 1 << DEPTH_LG2;
    localparam int c_ptr_w = DEPTH_LG2 + 1;

    localparam logic [c_ptr_w-1:0] c_one        = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0] c_depth_cnt  = c_ptr_w'(c_depth);
    localparam logic [c_ptr_w-1:0] c_afull_thr  = c_ptr_w'(AFULL_THRESH);
    localparam logic [c_ptr_w-1:0] c_aempty_thr = c_ptr_w'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [c_ptr_w-1:0]    r_wrptr;
    logic [c_ptr_w-1:0]    r_rdptr;
    logic [c_ptr_w-1:0]    r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;

    logic                  w_push;
    logic                  w_pop;
    logic [c_ptr_w-1:0]    w_count_next;
    logic [DEPTH_LG2-1:0]  w_wr_idx;
    logic [DEPTH_LG2-1:0]  w_rd_idx;

    // Qualification uses the registered flags, so a push into a full FIFO is
    // dropped even when a pop is accepted on the same edge.
    assign w_push   = wren_i & ~r_full  & ~clr_i;
    assign w_pop    = rden_i & ~r_empty & ~clr_i;
    assign w_wr_idx = r_wrptr[DEPTH_LG2-1:0];
    assign w_rd_idx = r_rdptr[DEPTH_LG2-1:0];

    always_comb begin
        w_count_next = r_count;
        if (clr_i) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + c_one;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_one;
        end
    end

    // Storage is reset but deliberately not touched by a flush.
    generate
        for (genvar g = 0; g < c_depth; g++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[g] <= '0;
                end else if (w_push && (w_wr_idx == DEPTH_LG2'(g))) begin
                    r_mem[g] <= wdata_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
        end else if (clr_i) begin
            r_wrptr <= '0;
            r_rdptr <= '0;
        end else begin
            if (w_push) begin
                r_wrptr <= r_wrptr + c_one;
            end
            if (w_pop) begin
                r_rdptr <= r_rdptr + c_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_count  <= w_count_next;
            r_full   <= (w_count_next == c_depth_cnt);
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= c_afull_thr);
            r_aempty <= (w_count_next <= c_aempty_thr);
        end
    end

`ifdef DMAC_FIFO_ERR_FLAG_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (clr_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wren_i && r_full) begin
                r_ovf <= 1'b1;
            end
            if (rden_i && r_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf_o = r_ovf;
    assign udf_o = r_udf;
`else
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

    assign rdata_o  = r_mem[w_rd_idx];
    assign full_o   = r_full;
    assign empty_o  = r_empty;
    assign afull_o  = r_afull;
    assign aempty_o = r_aempty;
    assign count_o  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dmac_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmac_fifo_fwft
// Brief    : Scoreboard bench for dmac_fifo_fwft: queue reference model,
//            directed corner cases and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmac_fifo_fwft;

    localparam int DEPTH_LG2 = 4;
    localparam int DEPTH     = 16;
    localparam int DW        = 32;
    localparam int AF        = 12;
    localparam int AE        = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clr_i;
    logic            wren_i;
    logic [DW-1:0]   wdata_i;
    logic            rden_i;
    logic            full_o;
    logic            afull_o;
    logic [DW-1:0]   rdata_o;
    logic            empty_o;
    logic            aempty_o;
    logic [DEPTH_LG2:0] count_o;
    logic            ovf_o;
    logic            udf_o;

    int n_checks = 0;
    int n_errors = 0;

    dmac_fifo_fwft #(
        .DEPTH_LG2(DEPTH_LG2), .DATA_WIDTH(DW),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
        .wren_i(wren_i), .wdata_i(wdata_i), .full_o(full_o), .afull_o(afull_o),
        .rden_i(rden_i), .rdata_o(rdata_o), .empty_o(empty_o), .aempty_o(aempty_o),
        .count_o(count_o), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted words plus sticky error bits.
    logic [DW-1:0] exp_q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    bit            m_push;
    bit            m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (clr_i) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_push = wren_i && (exp_q.size() < DEPTH);
            m_pop  = rden_i && (exp_q.size() > 0);
`ifdef DMAC_FIFO_ERR_FLAG_EN
            if (wren_i && exp_q.size() == DEPTH) m_ovf = 1'b1;
            if (rden_i && exp_q.size() == 0)     m_udf = 1'b1;
`endif
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(wdata_i);
        end
    end

    // Monitor: compare every visible output against the model away from posedge.
    int sz;
    always @(negedge clk) begin
        sz = exp_q.size();
        chk("count",  32'(count_o),  32'(sz));
        chk("empty",  32'(empty_o),  32'(sz == 0));
        chk("full",   32'(full_o),   32'(sz == DEPTH));
        chk("afull",  32'(afull_o),  32'(sz >= AF));
        chk("aempty", 32'(aempty_o), 32'(sz <= AE));
        chk("ovf",    32'(ovf_o),    32'(m_ovf));
        chk("udf",    32'(udf_o),    32'(m_udf));
        if (sz > 0) chk("rdata", rdata_o, exp_q[0]);
    end

    // Drive one cycle of inputs at a negedge and advance to the next negedge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        wren_i  = w;
        rden_i  = r;
        clr_i   = c;
        wdata_i = d;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"},  32'(count_o),  32'd0);
        chk({tag, "_empty"},  32'(empty_o),  32'd1);
        chk({tag, "_full"},   32'(full_o),   32'd0);
        chk({tag, "_afull"},  32'(afull_o),  32'd0);
        chk({tag, "_aempty"}, 32'(aempty_o), 32'd1);
        chk({tag, "_rdata"},  rdata_o,       32'd0);
        chk({tag, "_ovf"},    32'(ovf_o),    32'd0);
        chk({tag, "_udf"},    32'(udf_o),    32'd0);
    endtask

    int pw;
    int pr;

    initial begin
        rst_n = 1'b1; clr_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0; wdata_i = '0;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First word falls through after one edge.
        cyc(1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Fill to full, then one dropped push.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i));
        cyc(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);

        // Drain in order, then one extra pop on empty.
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Streaming at count 8 across pointer wraps.
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, $urandom);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, $urandom);

        // Push+pop while full, then push+pop while empty.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, $urandom);
        cyc(1'b1, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, $urandom);

        // Flush at count 5 beats simultaneous push and pop.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, $urandom);
        cyc(1'b1, 1'b1, 1'b1, $urandom);

        // Randomized traffic with varying push/pop bias and rare flushes.
        for (int blk = 0; blk < 15; blk++) begin
            pw = $urandom_range(100, 0);
            pr = $urandom_range(100, 0);
            for (int i = 0; i < 200; i++)
                cyc(($urandom % 100) < pw, ($urandom % 100) < pr,
                    ($urandom % 128) == 0, $urandom);
        end

        // Asynchronous reset in the middle of a cycle while streaming.
        for (int i = 0; i < 10; i++) cyc(1'b1, ($urandom % 2) == 1, 1'b0, $urandom);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cyc(($urandom % 2) == 1, ($urandom % 2) == 1, 1'b0, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dmac_fifo_fwft.md
# dmac_fifo_fwft

Parametrised first-word-fall-through (show-ahead) FIFO for DMAC read/write data buffering; the next-generation data buffer between the DMAC AXI read engine and write engine. Adds occupancy count, almost-full/almost-empty flags, synchronous flush and optional sticky overflow/underflow flags. The head entry is visible on `rdata_o` whenever the FIFO is non-empty, so a pop needs no read latency.

## Interface
- `DEPTH_LG2`, default 4: log2 of entry count; DEPTH = 1<<DEPTH_LG2; legal range ≥ 1.
- `DATA_WIDTH`, default 32: entry width in bits.
- `AFULL_THRESH`, default 12: `afull_o` asserts when count ≥ this value; legal range 1..DEPTH.
- `AEMPTY_THRESH`, default 2: `aempty_o` asserts when count ≤ this value; legal range 0..DEPTH-1.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr_i` in 1: synchronous flush.
- `wren_i` in 1: push request.
- `wdata_i` in DATA_WIDTH: push data.
- `full_o` out 1: count == DEPTH.
- `afull_o` out 1: count ≥ AFULL_THRESH.
- `rden_i` in 1: pop request; acknowledges the current head.
- `rdata_o` out DATA_WIDTH: head entry. Valid when `empty_o` = 0.
- `empty_o` out 1: count == 0.
- `aempty_o` out 1: count ≤ AEMPTY_THRESH.
- `count_o` out DEPTH_LG2+1: current occupancy, 0..DEPTH.
- `ovf_o` out 1: sticky overflow flag (see Configuration).
- `udf_o` out 1: sticky underflow flag (see Configuration).

## Operation
- Storage: DEPTH × DATA_WIDTH flop array. Write pointer and read pointer are each DEPTH_LG2+1 bits. Index = low DEPTH_LG2 bits; the MSB is the wrap bit. Pointers increment modulo 2^(DEPTH_LG2+1).
- Push accepted iff `wren_i` & ~`full_o` & ~`clr_i`: `mem[wrptr]` ← `wdata_i`, wrptr += 1.
- Pop accepted iff `rden_i` & ~`empty_o` & ~`clr_i`: rdptr += 1.
- Count rule: count_next = count + push − pop. A simultaneous push and pop leaves the count unchanged.
- Push while full is dropped, even if a pop is accepted in the same cycle. This is because `full_o` is registered state.
- Pop while empty is ignored. A simultaneous push into an empty FIFO is still accepted.
- `rdata_o` = mem[rdptr index], combinational from registered state. When `empty_o` = 1, `rdata_o` is don't-care (it shows a stale entry).
- `full_o`, `empty_o`, `afull_o`, `aempty_o` and `count_o` are all registered and are computed from count_next.
- `clr_i` has priority over push and pop. The cycle after `clr_i`: both pointers = 0, count = 0, `empty_o` = 1, `full_o` = 0. Storage contents are not cleared. `ovf_o`/`udf_o` are also cleared.
- Reset (asynchronous, mid-operation allowed): pointers 0, count 0, all storage entries 0, `empty_o` = 1, `full_o` = 0, `afull_o` = 0, `aempty_o` = 1, `rdata_o` = 0, `ovf_o` = 0, `udf_o` = 0.

## Timing
- Write-to-read latency: 1 cycle. A push at edge N gives `empty_o` = 0 and `rdata_o` = pushed data in cycle N+1.
- Pop at edge N: the next entry appears on `rdata_o` in cycle N+1. If the last entry was popped, `empty_o` = 1 in N+1.
- Flags and count change only on clock edges or asynchronous reset; there are no combinational paths from inputs to outputs.
- Full turnaround: a pop at edge N deasserts `full_o` in N+1. A push is accepted from edge N+1 onward.

## Configuration
- `DMAC_FIFO_ERR_FLAG_EN` defined:
  - `ovf_o` is set on any cycle with `wren_i` & `full_o` & ~`clr_i`.
  - `udf_o` is set on any cycle with `rden_i` & `empty_o` & ~`clr_i`.
  - Both are sticky until reset or `clr_i`, and update at the edge after the event.
- Not defined: `ovf_o` and `udf_o` are tied to 0 and no flag logic is generated. Ports remain present.

## Test plan
- Reset, then push 0xA5A5_0001 at edge 1 → cycle 2: `empty_o` = 0, `rdata_o` = 0xA5A5_0001, `count_o` = 1, `aempty_o` = 1.
- Push 16 words 0..15 with no pops (DEPTH_LG2 = 4) → `afull_o` rises when count reaches 12, `full_o` = 1 at count 16. A 17th push is dropped, count stays 16, and `ovf_o` = 1 (macro on) / 0 (macro off).
- Drain 16 pops → data 0..15 in order. `aempty_o` rises at count 2, `empty_o` = 1 after the last pop. A further pop gives `udf_o` = 1 (macro on); count stays 0.
- Streaming wrap: 40 cycles of simultaneous push/pop at count 8 → count constant at 8, output sequence matches input delayed by 8 pops, pointers wrap twice.
- Full with simultaneous push+pop → push dropped, count goes 16→15. Empty with simultaneous push+pop → pop ignored, count goes 0→1.
- `clr_i` at count 5 together with `wren_i`/`rden_i` → next cycle count 0, `empty_o` = 1, flags cleared. Then assert `rst_n` low mid-stream → all outputs return to reset values immediately, without waiting for a clock edge.
